// File: rtl/paralelo_serial_param_pkg.sv
// paralelo_serial_param_pkg: link-wide defaults, bit-order encoding and bit selection helper
package paralelo_serial_param_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam logic [7:0] DEF_IDLE_SYM = 8'hBC;
  localparam bit ORDER_MSB_FIRST = 1'b1;
  localparam bit ORDER_LSB_FIRST = 1'b0;
  function automatic int bit_sel(int cnt, int width, bit msb_first);
    return msb_first ? width - 1 - cnt : cnt;
  endfunction
endpackage

// File: rtl/fifo_sinc_param.sv
// fifo_sinc_param: synchronous FIFO with combinational head on rd_data
module fifo_sinc_param #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
)(
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNTW-1:0] count;
  logic do_push, do_pop;
  always_comb begin
    full = count == CNTW'(DEPTH);
    empty = count == '0;
    do_push = push && !full;
    do_pop = pop && !empty;
    rd_data = mem[rd_ptr];
  end
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= wr_data;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end
endmodule

// File: rtl/paralelo_serial_param.sv
// paralelo_serial_param: buffered parallel-to-serial converter that fills empty slots with IDLE_SYM
module paralelo_serial_param
  import paralelo_serial_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter logic [WIDTH-1:0] IDLE_SYM = WIDTH'(DEF_IDLE_SYM),
  parameter bit MSB_FIRST = ORDER_MSB_FIRST
)(
  input  logic             clk_32f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic [WIDTH-1:0] data2send,
  output logic             word_start,
  output logic             idle_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  logic [CW-1:0] cnt, idx;
  logic [WIDTH-1:0] head;
  logic full, empty, push, pop, boundary;
  always_comb begin
    boundary = cnt == LAST;
    push = valid_in && ready_out;
    pop = boundary && !empty;
    idx = CW'(bit_sel(int'(cnt), WIDTH, MSB_FIRST));
  end
  assign ready_out = !full;
  assign data_out = data2send[idx];
  assign word_start = cnt == '0;
  fifo_sinc_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk_32f(clk_32f),
    .reset(reset),
    .push(push),
    .pop(pop),
    .wr_data(data_in),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  // The load decision uses pre-edge emptiness, so a word pushed on the boundary waits a full word.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      cnt <= '0;
      data2send <= IDLE_SYM;
      idle_out <= 1'b1;
    end else begin
      cnt <= boundary ? '0 : cnt + CW'(1);
      if (boundary) begin
        data2send <= empty ? IDLE_SYM : head;
        idle_out <= empty;
      end
    end
  end
endmodule

// File: tb/tb_paralelo_serial_param.sv
// tb_paralelo_serial_param: scoreboard bench for the 8-bit MSB-first and 10-bit LSB-first variants
module tb_paralelo_serial_param;
  logic clk_32f = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data_in = '0;
  logic valid_in = 1'b0;
  logic ready_out, data_out, word_start, idle_out;
  logic [7:0] data2send;
  logic [9:0] data_in_b = '0;
  logic valid_in_b = 1'b0;
  logic ready_out_b, data_out_b, word_start_b, idle_out_b;
  logic [9:0] data2send_b;
  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];
  logic [9:0] sb_b[$];
  bit done_b = 1'b0;

  paralelo_serial_param dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .data_out(data_out), .data2send(data2send),
    .word_start(word_start), .idle_out(idle_out)
  );

  paralelo_serial_param #(.WIDTH(10), .DEPTH(4), .IDLE_SYM(10'h17C), .MSB_FIRST(1'b0)) dut_b (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in_b), .valid_in(valid_in_b),
    .ready_out(ready_out_b), .data_out(data_out_b), .data2send(data2send_b),
    .word_start(word_start_b), .idle_out(idle_out_b)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ws(input bit ten);
    int n = 0;
    do begin
      @(negedge clk_32f);
      n++;
    end while (!(ten ? word_start_b : word_start) && n < 40);
    chk(ten ? "ws_timeout_b" : "ws_timeout", ten ? word_start_b : word_start, 1);
  endtask

  task automatic send(input logic [7:0] w);
    int n = 0;
    data_in = w;
    valid_in = 1'b1;
    while (!ready_out && n < 100) begin
      @(negedge clk_32f);
      n++;
    end
    chk("send_ready", ready_out, 1);
    sb.push_back(w);
    @(negedge clk_32f);
    valid_in = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] w);
    int n = 0;
    data_in_b = w;
    valid_in_b = 1'b1;
    while (!ready_out_b && n < 100) begin
      @(negedge clk_32f);
      n++;
    end
    chk("send_ready_b", ready_out_b, 1);
    sb_b.push_back(w);
    @(negedge clk_32f);
    valid_in_b = 1'b0;
  endtask

  // Monitor for the 8-bit MSB-first instance: rebuilds each serial word and checks it.
  initial begin
    int i = 0;
    logic [7:0] cur, sh;
    logic idl;
    cur = '0; sh = '0; idl = 1'b1;
    forever begin
      @(negedge clk_32f);
      if (reset) i = 0;
      else begin
        if (word_start) begin
          cur = data2send; idl = idle_out; sh = {7'b0, data_out}; i = 1;
        end else if (i > 0) begin
          sh = {sh[6:0], data_out}; i++;
        end
        if (i == 8) begin
          i = 0;
          chk("serial_a", sh, cur);
          if (idl) chk("idle_sym_a", cur, 8'hBC);
          else if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL order_a: got %0h expected none (queue empty)", cur);
          end else chk("order_a", cur, sb.pop_front());
        end
      end
    end
  end

  // Monitor for the 10-bit LSB-first instance.
  initial begin
    int i = 0;
    logic [9:0] cur, sh;
    logic idl;
    cur = '0; sh = '0; idl = 1'b1;
    forever begin
      @(negedge clk_32f);
      if (reset) i = 0;
      else begin
        if (word_start_b) begin
          cur = data2send_b; idl = idle_out_b; sh = '0; sh[0] = data_out_b; i = 1;
        end else if (i > 0) begin
          sh[i] = data_out_b; i++;
        end
        if (i == 10) begin
          i = 0;
          chk("serial_b", sh, cur);
          if (idl) chk("idle_sym_b", cur, 10'h17C);
          else if (sb_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL order_b: got %0h expected none (queue empty)", cur);
          end else chk("order_b", cur, sb_b.pop_front());
        end
      end
    end
  end

  initial begin
    logic [9:0] exp_b;
    int n;
    exp_b = 10'h2A5;
    n = 0;
    while (reset && n < 100) begin
      @(negedge clk_32f);
      n++;
    end
    wait_ws(1);
    n = 0;
    do begin
      @(negedge clk_32f);
      n++;
    end while (!word_start_b && n < 30);
    chk("period_b", n, 10);
    chk("idle_out_b", idle_out_b, 1);
    chk("idle_word_b", data2send_b, 10'h17C);
    send_b(10'h2A5);
    wait_ws(1);
    chk("load_b", data2send_b, 10'h2A5);
    chk("load_idle_b", idle_out_b, 0);
    for (int j = 0; j < 10; j++) begin
      chk("lsb_bit_b", data_out_b, exp_b[j]);
      @(negedge clk_32f);
    end
    chk("period2_b", word_start_b, 1);
    chk("after_b", idle_out_b, 1);
    done_b = 1'b1;
  end

  initial begin
    logic [7:0] idle_pat;
    int n;
    idle_pat = 8'hBC;
    reset = 1'b1;
    valid_in = 1'b1;
    data_in = 8'hEE;
    repeat (3) @(posedge clk_32f);
    @(negedge clk_32f);
    chk("rst_ready", ready_out, 1);
    chk("rst_ws", word_start, 1);
    chk("rst_idle", idle_out, 1);
    chk("rst_word", data2send, 8'hBC);
    chk("rst_bit", data_out, 1);
    valid_in = 1'b0;
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      chk("idle_bit", data_out, idle_pat[7 - (j % 8)]);
      chk("idle_ws", word_start, (j % 8) == 0);
      chk("idle_flag", idle_out, 1);
      chk("idle_ready", ready_out, 1);
      @(negedge clk_32f);
    end
    repeat (3) @(negedge clk_32f);
    send(8'hA5);
    wait_ws(0);
    chk("a5_load", data2send, 8'hA5);
    chk("a5_idle", idle_out, 0);
    wait_ws(0);
    chk("a5_next", data2send, 8'hBC);
    chk("a5_next_idle", idle_out, 1);
    for (int k = 1; k <= 4; k++) send(8'(k));
    chk("full_ready", ready_out, 0);
    send(8'h05);
    chk("burst_1", data2send, 8'h01);
    chk("burst_1_idle", idle_out, 0);
    for (int k = 2; k <= 5; k++) begin
      wait_ws(0);
      chk("burst_k", data2send, k);
      chk("burst_gap", idle_out, 0);
    end
    wait_ws(0);
    chk("burst_end", idle_out, 1);
    repeat (7) @(negedge clk_32f);
    send(8'h3C);
    chk("bnd_idle_word", data2send, 8'hBC);
    chk("bnd_idle_flag", idle_out, 1);
    wait_ws(0);
    chk("bnd_load", data2send, 8'h3C);
    chk("bnd_load_idle", idle_out, 0);
    wait_ws(0);
    chk("bnd_after", idle_out, 1);
    n = 0;
    while (!done_b && n < 500) begin
      @(negedge clk_32f);
      n++;
    end
    chk("done_b", done_b, 1);
    wait_ws(0);
    send(8'hF0);
    send(8'h11);
    send(8'h22);
    wait_ws(0);
    chk("f0_load", data2send, 8'hF0);
    repeat (4) @(negedge clk_32f);
    reset = 1'b1;
    sb.delete();
    sb_b.delete();
    @(negedge clk_32f);
    chk("mid_rst_word", data2send, 8'hBC);
    chk("mid_rst_ws", word_start, 1);
    chk("mid_rst_ready", ready_out, 1);
    chk("mid_rst_idle", idle_out, 1);
    chk("mid_rst_bit", data_out, 1);
    reset = 1'b0;
    send(8'h5A);
    wait_ws(0);
    chk("post_rst_load", data2send, 8'h5A);
    chk("post_rst_idle", idle_out, 0);
    wait_ws(0);
    chk("post_rst_flush", data2send, 8'hBC);
    chk("post_rst_flag", idle_out, 1);
    wait_ws(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
